// File: rtl/branch_ctrl_pkg.sv
// Shared encodings for the execute-stage branch/jump resolution controller:
// instruction kinds, branch condition codes, exception causes and FSM states.
package branch_ctrl_pkg;

  typedef enum logic [1:0] {
    KIND_BR   = 2'b00,
    KIND_JAL  = 2'b01,
    KIND_JALR = 2'b10,
    KIND_ILL  = 2'b11
  } kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] EXC_ILLEGAL  = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_EVAL  = 2'd1;
  localparam state_t ST_REDIR = 2'd2;

  // Codes 010/011 are reserved branch conditions
  function automatic logic br_f3_legal(input logic [2:0] f3);
    return (f3[2:1] != 2'b01);
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Decode-to-branch issue channel plus the branch-to-fetch redirect channel.
interface branch_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [31:0] in_imm;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;

  modport slave (
    input  in_valid, in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm, redir_ready,
    output in_ready, redir_valid, redir_pc
  );

  modport master (
    output in_valid, in_kind, in_funct3, in_pc, in_rs1, in_rs2, in_imm, redir_ready,
    input  in_ready, redir_valid, redir_pc
  );
endinterface

// File: rtl/branch_ctrl_compare.sv
// Branch condition comparator: evaluates the funct3 condition op on in1/in2.
module compare
  import branch_ctrl_pkg::*;
(
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [2:0]  op,
  output logic        out
);

  // Condition select; reserved codes never take
  always_comb begin
    case (op)
      F3_BEQ:  out = (in1 == in2);
      F3_BNE:  out = (in1 != in2);
      F3_BLT:  out = ($signed(in1) < $signed(in2));
      F3_BGE:  out = ($signed(in1) >= $signed(in2));
      F3_BLTU: out = (in1 < in2);
      F3_BGEU: out = (in1 >= in2);
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_ctrl.sv
// Execute-stage branch/jump resolution: evaluates one control transfer at a time
// and drives the fetch redirect, pipeline flush, link writeback and statistics.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  branch_ctrl_if.slave     bus,
  output logic             flush,
  output logic             link_valid,
  output logic [31:0]      link_data,
  output logic             done,
  output logic             exc_valid,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_r;
  kind_e            kind_r;
  logic [2:0]       funct3_r;
  logic [31:0]      pc_r, rs1_r, rs2_r, imm_r;
  logic             redir_valid_r, flush_r, link_valid_r, done_r, exc_valid_r;
  logic [31:0]      redir_pc_r, link_data_r;
  logic [1:0]       exc_cause_r;
  logic [CNT_W-1:0] br_cnt_r, taken_cnt_r;

  logic             cmp_s, is_br_s, is_jalr_s, illegal_s, taken_s, misalign_s;
  logic [31:0]      base_s, sum_s, target_s, link_s;

  compare u_compare (
    .in1 (rs1_r),
    .in2 (rs2_r),
    .op  (funct3_r),
    .out (cmp_s)
  );

  // Outcome of the latched instruction; only consumed while in EVAL
  always_comb begin
    is_br_s    = (kind_r == KIND_BR);
    is_jalr_s  = (kind_r == KIND_JALR);
    illegal_s  = (kind_r == KIND_ILL) || (is_br_s && !br_f3_legal(funct3_r));
    base_s     = is_jalr_s ? rs1_r : pc_r;
    sum_s      = base_s + imm_r;
    target_s   = is_jalr_s ? {sum_s[31:1], 1'b0} : sum_s;
    taken_s    = is_br_s ? cmp_s : 1'b1;
    misalign_s = taken_s && (target_s[1:0] != 2'b00);
    link_s     = pc_r + 32'd4;
  end

  // Sequencing FSM, operand latch, pulsed results and saturating statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      kind_r        <= KIND_BR;
      funct3_r      <= 3'd0;
      pc_r          <= 32'd0;
      rs1_r         <= 32'd0;
      rs2_r         <= 32'd0;
      imm_r         <= 32'd0;
      redir_valid_r <= 1'b0;
      redir_pc_r    <= 32'd0;
      flush_r       <= 1'b0;
      link_valid_r  <= 1'b0;
      link_data_r   <= 32'd0;
      done_r        <= 1'b0;
      exc_valid_r   <= 1'b0;
      exc_cause_r   <= 2'b00;
      br_cnt_r      <= '0;
      taken_cnt_r   <= '0;
    end else begin
      flush_r      <= 1'b0;
      link_valid_r <= 1'b0;
      link_data_r  <= 32'd0;
      done_r       <= 1'b0;
      exc_valid_r  <= 1'b0;
      exc_cause_r  <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            kind_r   <= kind_e'(bus.in_kind);
            funct3_r <= bus.in_funct3;
            pc_r     <= bus.in_pc;
            rs1_r    <= bus.in_rs1;
            rs2_r    <= bus.in_rs2;
            imm_r    <= bus.in_imm;
            state_r  <= ST_EVAL;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_EVAL: begin
          // Misaligned branches still count as resolved (and taken)
          if (is_br_s && !illegal_s) begin
            if (br_cnt_r != CNT_MAX) br_cnt_r <= br_cnt_r + CNT_ONE;
            if (taken_s && (taken_cnt_r != CNT_MAX)) taken_cnt_r <= taken_cnt_r + CNT_ONE;
          end
          if (illegal_s) begin
            exc_valid_r <= 1'b1;
            exc_cause_r <= EXC_ILLEGAL;
            done_r      <= 1'b1;
            state_r     <= ST_IDLE;
          end else if (misalign_s) begin
            exc_valid_r <= 1'b1;
            exc_cause_r <= EXC_MISALIGN;
            done_r      <= 1'b1;
            state_r     <= ST_IDLE;
          end else if (taken_s) begin
            flush_r       <= 1'b1;
            redir_valid_r <= 1'b1;
            redir_pc_r    <= target_s;
            link_valid_r  <= !is_br_s;
            link_data_r   <= is_br_s ? 32'd0 : link_s;
            state_r       <= ST_REDIR;
          end else begin
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        ST_REDIR: begin
          if (bus.redir_ready) begin
            redir_valid_r <= 1'b0;
            redir_pc_r    <= 32'd0;
            done_r        <= 1'b1;
            state_r       <= ST_IDLE;
          end else begin
            state_r       <= ST_REDIR;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_r == ST_IDLE) && !rst;
  assign bus.redir_valid = redir_valid_r;
  assign bus.redir_pc    = redir_pc_r;
  assign flush           = flush_r;
  assign link_valid      = link_valid_r;
  assign link_data       = link_data_r;
  assign done            = done_r;
  assign exc_valid       = exc_valid_r;
  assign exc_cause       = exc_cause_r;
  assign br_cnt          = br_cnt_r;
  assign taken_cnt       = taken_cnt_r;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl: directed scenarios plus randomized instructions checked
// against an arithmetic reference model; a CNT_W=2 copy exercises saturation.
module tb_branch_ctrl;
  import branch_ctrl_pkg::*;

  typedef struct packed {
    logic        ill;
    logic        taken;
    logic        mis;
    logic [31:0] tgt;
    logic [31:0] link;
  } res_t;

  logic        clk;
  logic        rst;
  logic        flush, link_valid, done, exc_valid;
  logic [31:0] link_data;
  logic [1:0]  exc_cause;
  logic [15:0] br_cnt, taken_cnt;
  logic        s_flush, s_link_valid, s_done, s_exc_valid;
  logic [31:0] s_link_data;
  logic [1:0]  s_exc_cause;
  logic [1:0]  s_br_cnt, s_taken_cnt;
  logic [5:0]  st_v, st2_v;
  int          n_checks, n_fail, br_n, tk_n;

  branch_ctrl_if bi ();
  branch_ctrl_if bs ();

  branch_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bi), .flush(flush), .link_valid(link_valid),
    .link_data(link_data), .done(done), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  branch_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bs), .flush(s_flush), .link_valid(s_link_valid),
    .link_data(s_link_data), .done(s_done), .exc_valid(s_exc_valid), .exc_cause(s_exc_cause),
    .br_cnt(s_br_cnt), .taken_cnt(s_taken_cnt)
  );

  assign bs.in_valid    = bi.in_valid;
  assign bs.in_kind     = bi.in_kind;
  assign bs.in_funct3   = bi.in_funct3;
  assign bs.in_pc       = bi.in_pc;
  assign bs.in_rs1      = bi.in_rs1;
  assign bs.in_rs2      = bi.in_rs2;
  assign bs.in_imm      = bi.in_imm;
  assign bs.redir_ready = bi.redir_ready;

  // {in_ready, flush, redir_valid, link_valid, done, exc_valid}
  assign st_v  = {bi.in_ready, flush, bi.redir_valid, link_valid, done, exc_valid};
  assign st2_v = {bs.in_ready, s_flush, bs.redir_valid, s_link_valid, s_done, s_exc_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic res_t ref_model(input logic [1:0] k, input logic [2:0] f3,
                                     input logic [31:0] pc, input logic [31:0] rs1,
                                     input logic [31:0] rs2, input logic [31:0] imm);
    res_t r;
    longint sa, sb;
    logic [63:0] base, sum;
    r  = '0;
    sa = longint'($signed(rs1));
    sb = longint'($signed(rs2));
    r.ill   = (k == 2'b11);
    r.taken = 1'b1;
    if (k == 2'b00) begin
      case (f3)
        3'b000:  r.taken = (rs1 == rs2);
        3'b001:  r.taken = (rs1 != rs2);
        3'b100:  r.taken = (sa < sb);
        3'b101:  r.taken = (sa >= sb);
        3'b110:  r.taken = ({32'd0, rs1} < {32'd0, rs2});
        3'b111:  r.taken = ({32'd0, rs1} >= {32'd0, rs2});
        default: r.ill = 1'b1;
      endcase
    end
    if (r.ill) r.taken = 1'b0;
    base = (k == 2'b10) ? {32'd0, rs1} : {32'd0, pc};
    sum  = (base + {32'd0, imm}) % 64'h1_0000_0000;
    if (k == 2'b10) sum = sum - (sum % 64'd2);
    r.tgt = sum[31:0];
    r.mis = r.taken && ((sum % 64'd4) != 64'd0);
    sum   = ({32'd0, pc} + 64'd4) % 64'h1_0000_0000;
    r.link = sum[31:0];
    return r;
  endfunction

  function automatic logic [15:0] sat16(input int n);
    return (n > 65535) ? 16'hFFFF : 16'(n);
  endfunction

  function automatic logic [1:0] sat2(input int n);
    return (n > 3) ? 2'd3 : 2'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] k, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    bi.in_valid  = 1'b1;
    bi.in_kind   = k;
    bi.in_funct3 = f3;
    bi.in_pc     = pc;
    bi.in_rs1    = rs1;
    bi.in_rs2    = rs2;
    bi.in_imm    = imm;
    tick();
    bi.in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bi.in_valid = 1'b0;
    bi.redir_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    br_n = 0;
    tk_n = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bi.in_valid = 1'b1;
    tick();
    tick();
    n_checks++; if (st_v !== 6'b000000) begin n_fail++; $display("FAIL rst_status: got %b want 000000", st_v); end
    n_checks++; if ({link_data, exc_cause, bi.redir_pc, br_cnt, taken_cnt} !== '0) begin n_fail++; $display("FAIL rst_values: got %h/%h/%h/%h/%h want all 0", link_data, exc_cause, bi.redir_pc, br_cnt, taken_cnt); end
    rst = 1'b0;
    bi.in_valid = 1'b0;
    tick();
    n_checks++; if (st_v !== 6'b100000) begin n_fail++; $display("FAIL rst_release: got %b want 100000", st_v); end
  endtask

  task automatic test_beq_backpressure();
    do_reset();
    issue(2'b00, 3'b000, 32'h100, 32'd5, 32'd5, 32'h20);
    n_checks++; if (st_v !== 6'b000000) begin n_fail++; $display("FAIL beq_eval: got %b want 000000", st_v); end
    tick();
    n_checks++; if (st_v !== 6'b011000) begin n_fail++; $display("FAIL beq_first: got %b want 011000", st_v); end
    n_checks++; if (bi.redir_pc !== 32'h120) begin n_fail++; $display("FAIL beq_target: got %h want 00000120", bi.redir_pc); end
    for (int j = 0; j < 3; j++) begin
      tick();
      n_checks++; if ({st_v, bi.redir_pc} !== {6'b001000, 32'h120}) begin n_fail++; $display("FAIL beq_hold: got %b/%h want 001000/00000120", st_v, bi.redir_pc); end
    end
    bi.redir_ready = 1'b1;
    tick();
    n_checks++; if (st_v !== 6'b100010) begin n_fail++; $display("FAIL beq_done: got %b want 100010", st_v); end
    n_checks++; if ({br_cnt, taken_cnt} !== {16'd1, 16'd1}) begin n_fail++; $display("FAIL beq_counts: got %0d/%0d want 1/1", br_cnt, taken_cnt); end
    bi.redir_ready = 1'b0;
    tick();
    n_checks++; if (st_v !== 6'b100000) begin n_fail++; $display("FAIL beq_quiet: got %b want 100000", st_v); end
  endtask

  task automatic test_bltu_not_taken();
    do_reset();
    issue(2'b00, 3'b110, 32'h104, 32'hFFFF_FFFF, 32'd1, 32'h40);
    tick();
    n_checks++; if (st_v !== 6'b100010) begin n_fail++; $display("FAIL bltu_done: got %b want 100010", st_v); end
    n_checks++; if ({br_cnt, taken_cnt} !== {16'd1, 16'd0}) begin n_fail++; $display("FAIL bltu_counts: got %0d/%0d want 1/0", br_cnt, taken_cnt); end
    tick();
    n_checks++; if (st_v !== 6'b100000) begin n_fail++; $display("FAIL bltu_quiet: got %b want 100000", st_v); end
  endtask

  task automatic test_jalr();
    bi.redir_ready = 1'b1;
    issue(2'b10, 3'b000, 32'h200, 32'h1001, 32'd0, 32'd0);
    tick();
    n_checks++; if (st_v !== 6'b011100) begin n_fail++; $display("FAIL jalr_first: got %b want 011100", st_v); end
    n_checks++; if ({bi.redir_pc, link_data} !== {32'h1000, 32'h204}) begin n_fail++; $display("FAIL jalr_pc_link: got %h/%h want 00001000/00000204", bi.redir_pc, link_data); end
    tick();
    n_checks++; if (st_v !== 6'b100010) begin n_fail++; $display("FAIL jalr_done: got %b want 100010", st_v); end
    n_checks++; if ({br_cnt, taken_cnt} !== {16'd1, 16'd0}) begin n_fail++; $display("FAIL jalr_counts: got %0d/%0d want 1/0", br_cnt, taken_cnt); end
    bi.redir_ready = 1'b0;
  endtask

  task automatic test_jal_misaligned();
    issue(2'b01, 3'b000, 32'h300, 32'd0, 32'd0, 32'h6);
    tick();
    n_checks++; if (st_v !== 6'b100011) begin n_fail++; $display("FAIL jal_mis_status: got %b want 100011", st_v); end
    n_checks++; if (exc_cause !== 2'b01) begin n_fail++; $display("FAIL jal_mis_cause: got %b want 01", exc_cause); end
    tick();
    n_checks++; if (st_v !== 6'b100000) begin n_fail++; $display("FAIL jal_mis_quiet: got %b want 100000", st_v); end
  endtask

  task automatic test_illegal_then_reset();
    issue(2'b00, 3'b010, 32'h400, 32'd7, 32'd7, 32'h10);
    tick();
    n_checks++; if ({st_v, exc_cause} !== {6'b100011, 2'b00}) begin n_fail++; $display("FAIL ill_f3: got %b/%b want 100011/00", st_v, exc_cause); end
    n_checks++; if (br_cnt !== 16'd1) begin n_fail++; $display("FAIL ill_br_cnt: got %0d want 1", br_cnt); end
    issue(2'b11, 3'b000, 32'h404, 32'd0, 32'd0, 32'h8);
    tick();
    n_checks++; if ({st_v, exc_cause} !== {6'b100011, 2'b00}) begin n_fail++; $display("FAIL ill_kind: got %b/%b want 100011/00", st_v, exc_cause); end
    bi.redir_ready = 1'b0;
    issue(2'b00, 3'b000, 32'h500, 32'd9, 32'd9, 32'h40);
    tick();
    n_checks++; if (st_v !== 6'b011000) begin n_fail++; $display("FAIL rst_pre: got %b want 011000", st_v); end
    rst = 1'b1;
    tick();
    n_checks++; if ({st_v, link_data, exc_cause, bi.redir_pc, br_cnt, taken_cnt} !== '0) begin n_fail++; $display("FAIL rst_mid_redir: got %b/%h/%h/%0d/%0d want all 0", st_v, bi.redir_pc, link_data, br_cnt, taken_cnt); end
    rst = 1'b0;
    tick();
    n_checks++; if (st_v !== 6'b100000) begin n_fail++; $display("FAIL rst_mid_idle: got %b want 100000", st_v); end
    tick();
    n_checks++; if (st_v !== 6'b100000) begin n_fail++; $display("FAIL rst_mid_nodone: got %b want 100000", st_v); end
  endtask

  task automatic test_saturation_and_wrap();
    do_reset();
    bi.redir_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      issue(2'b00, 3'b100, 32'h600, 32'hFFFF_FFFF, 32'd0, 32'h8);
      tick();
      tick();
    end
    n_checks++; if ({s_br_cnt, s_taken_cnt} !== 4'b1111) begin n_fail++; $display("FAIL sat_cnt2: got %0d/%0d want 3/3", s_br_cnt, s_taken_cnt); end
    n_checks++; if ({br_cnt, taken_cnt} !== {16'd5, 16'd5}) begin n_fail++; $display("FAIL sat_cnt16: got %0d/%0d want 5/5", br_cnt, taken_cnt); end
    issue(2'b01, 3'b000, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8);
    tick();
    n_checks++; if (st_v !== 6'b011100) begin n_fail++; $display("FAIL wrap_first: got %b want 011100", st_v); end
    n_checks++; if ({bi.redir_pc, link_data} !== {32'h4, 32'h0}) begin n_fail++; $display("FAIL wrap_pc_link: got %h/%h want 00000004/00000000", bi.redir_pc, link_data); end
    tick();
    n_checks++; if (st_v !== 6'b100010) begin n_fail++; $display("FAIL wrap_done: got %b want 100010", st_v); end
    bi.redir_ready = 1'b0;
  endtask

  task automatic test_random(input int n);
    res_t        e;
    logic [1:0]  k;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic        redir_exp;
    logic [5:0]  exp_st;
    int          stall, sel;
    do_reset();
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 9);
      k   = (sel < 6) ? 2'b00 : (sel < 8) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      f3  = 3'($urandom_range(0, 7));
      rs1 = $urandom;
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : $urandom;
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFC;
      stall = $urandom_range(0, 3);
      e = ref_model(k, f3, pc, rs1, rs2, imm);
      redir_exp = e.taken && !e.ill && !e.mis;
      issue(k, f3, pc, rs1, rs2, imm);
      // Offer junk while busy; it must be ignored
      bi.in_valid = 1'($urandom_range(0, 1));
      bi.in_pc    = $urandom;
      bi.in_rs1   = $urandom;
      bi.in_kind  = 2'($urandom_range(0, 3));
      bi.redir_ready = (stall == 0);
      n_checks++; if (st_v !== 6'b000000) begin n_fail++; $display("FAIL rnd_eval[%0d]: got %b want 000000", i, st_v); end
      tick();
      bi.in_valid = 1'b0;
      if (!e.ill && (k == 2'b00)) begin
        br_n++;
        if (e.taken) tk_n++;
      end
      n_checks++; if ({br_cnt, taken_cnt} !== {sat16(br_n), sat16(tk_n)}) begin n_fail++; $display("FAIL rnd_cnt16[%0d]: got %0d/%0d want %0d/%0d", i, br_cnt, taken_cnt, sat16(br_n), sat16(tk_n)); end
      n_checks++; if ({s_br_cnt, s_taken_cnt} !== {sat2(br_n), sat2(tk_n)}) begin n_fail++; $display("FAIL rnd_cnt2[%0d]: got %0d/%0d want %0d/%0d", i, s_br_cnt, s_taken_cnt, sat2(br_n), sat2(tk_n)); end
      if (!redir_exp) begin
        exp_st = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, e.ill | e.mis};
        n_checks++; if ({st_v, st2_v} !== {exp_st, exp_st}) begin n_fail++; $display("FAIL rnd_result[%0d]: got %b/%b want %b (k=%b f3=%b)", i, st_v, st2_v, exp_st, k, f3); end
        if (e.ill || e.mis) begin
          n_checks++; if ({exc_cause, s_exc_cause} !== {2{e.ill ? 2'b00 : 2'b01}}) begin n_fail++; $display("FAIL rnd_cause[%0d]: got %b/%b want ill=%b", i, exc_cause, s_exc_cause, e.ill); end
        end
      end else begin
        exp_st = {1'b0, 1'b1, 1'b1, k != 2'b00, 1'b0, 1'b0};
        n_checks++; if ({st_v, st2_v} !== {exp_st, exp_st}) begin n_fail++; $display("FAIL rnd_first[%0d]: got %b/%b want %b", i, st_v, st2_v, exp_st); end
        n_checks++; if ({bi.redir_pc, bs.redir_pc} !== {e.tgt, e.tgt}) begin n_fail++; $display("FAIL rnd_target[%0d]: got %h/%h want %h", i, bi.redir_pc, bs.redir_pc, e.tgt); end
        if (k != 2'b00) begin
          n_checks++; if ({link_data, s_link_data} !== {e.link, e.link}) begin n_fail++; $display("FAIL rnd_link[%0d]: got %h/%h want %h", i, link_data, s_link_data, e.link); end
        end
        for (int j = 0; j < stall; j++) begin
          tick();
          n_checks++; if ({st_v, bi.redir_pc} !== {6'b001000, e.tgt}) begin n_fail++; $display("FAIL rnd_hold[%0d]: got %b/%h want 001000/%h", i, st_v, bi.redir_pc, e.tgt); end
          if (j == stall - 1) bi.redir_ready = 1'b1;
        end
        tick();
        n_checks++; if (st_v !== 6'b100010) begin n_fail++; $display("FAIL rnd_done[%0d]: got %b want 100010", i, st_v); end
        bi.redir_ready = 1'b0;
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    br_n = 0;
    tk_n = 0;
    rst = 1'b1;
    bi.in_valid = 1'b0;
    bi.in_kind = 2'b00;
    bi.in_funct3 = 3'b000;
    bi.in_pc = 32'd0;
    bi.in_rs1 = 32'd0;
    bi.in_rs2 = 32'd0;
    bi.in_imm = 32'd0;
    bi.redir_ready = 1'b0;
    test_reset();
    test_beq_backpressure();
    test_bltu_not_taken();
    test_jalr();
    test_jal_misaligned();
    test_illegal_then_reset();
    test_saturation_and_wrap();
    test_random(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
